// File: rtl/mul_seq.sv
// mul_seq: multi-cycle MUL/MLA sequencer driving an ALU through a shift-and-add loop.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, accumulate         issue request, MLA select (captured with start)
//   op_a, op_b, op_acc        multiplicand, multiplier, addend (captured with start)
//   flush                     synchronous abort of an in-flight operation
//   busy, done                high while iterating / one-cycle completion pulse
//   result, flag_n, flag_z    low product bits (+ addend) with N/Z flags, held until next completion

// Team ALU: combinational function unit selected by selectCase.
module alu #(
    parameter int unsigned W = 32
) (
    input  logic [3:0]   selectCase,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] out
);
    always_comb begin
        out = a;
        case (selectCase)
            4'd0:    out = a + b;
            4'd1:    out = a - b;
            4'd2:    out = a & b;
            4'd3:    out = a | b;
            4'd4:    out = a ^ b;
            default: out = a;
        endcase
    end
endmodule

module mul_seq #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            accumulate,
    input  logic [size-1:0] op_a,
    input  logic [size-1:0] op_b,
    input  logic [size-1:0] op_acc,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] result,
    output logic            flag_n,
    output logic            flag_z
);
    localparam int unsigned CW = $clog2(size) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [size-1:0] mcand;
    logic [size-1:0] mplier;
    logic [size-1:0] acc;
    logic [CW-1:0]   cnt;
    logic [3:0]      alu_sel;
    logic [size-1:0] alu_a;
    logic [size-1:0] alu_b;
    logic [size-1:0] alu_out;
    logic            loop_end;

    // The loop ends early once no multiplier bits remain.
    assign loop_end = (mplier == '0) || (cnt == CW'(size));

    alu #(.W(size)) u_alu (
        .selectCase (alu_sel),
        .a          (alu_a),
        .b          (alu_b),
        .out        (alu_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush outranks loop completion.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_ITER;
            S_ITER: begin
                if (flush)         state_nxt = S_IDLE;
                else if (loop_end) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ALU drive: add acc + mcand while iterating, otherwise idle at zero.
    always_comb begin
        alu_sel = 4'd0;
        alu_a   = '0;
        alu_b   = '0;
        if (state == S_ITER) begin
            alu_a = acc;
            alu_b = mcand;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= accumulate ? op_acc : '0;
                        cnt    <= '0;
                    end
                end
                S_ITER: begin
                    if (!flush) begin
                        if (loop_end) begin
                            result <= acc;
                            flag_n <= acc[size-1];
                            flag_z <= (acc == '0);
                        end else begin
                            if (mplier[0]) acc <= alu_out;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                            cnt    <= cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // busy/done registered from the next state so they align with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_ITER);
            done <= (state_nxt == S_DONE);
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        accumulate;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_acc;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_n;
    logic        flag_z;

    int vectors = 0;
    int miscompares = 0;

    mul_seq #(.size(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .accumulate (accumulate),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_acc     (op_acc),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flag_n     (flag_n),
        .flag_z     (flag_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] acc;
        logic        accum;
        logic [31:0] exp_res;
        int          exp_n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operation definition.
    function automatic logic [31:0] model_res(logic [31:0] a, logic [31:0] b,
                                              logic [31:0] acc, logic accum);
        logic [63:0] p;
        p = 64'(a) * 64'(b) + (accum ? 64'(acc) : 64'd0);
        return p[31:0];
    endfunction

    function automatic int model_n(logic [31:0] b);
        int msb;
        if (b == 32'd0) return 1;
        msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return msb + 2;
    endfunction

    // Issue one operation and check latency, done pulse, result and flags.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                          input logic accum, input logic [31:0] exp_res, input int exp_n,
                          input string tag);
        int n;
        @(negedge clk);
        op_a = a; op_b = b; op_acc = acc; accumulate = accum; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (done) chk({tag, " busy_and_done"}, 32'(done), 32'd0);
            n++;
            @(posedge clk); #1;
        end
        chk({tag, " iter_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " flag_n"}, 32'(flag_n), 32'(exp_res[31]));
        chk({tag, " flag_z"}, 32'(flag_z), 32'(exp_res == 32'd0));
        @(posedge clk); #1;
        chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    endtask

    vec_t tbl[5];

    initial begin
        int pulses;
        logic [31:0] ra, rb, rc;
        logic        rm;

        tbl[0] = '{a: 32'd6,          b: 32'd7,          acc: 32'd0,          accum: 1'b0, exp_res: 32'd42,         exp_n: 4};
        tbl[1] = '{a: 32'h0000_1234,  b: 32'd0,          acc: 32'd5,          accum: 1'b1, exp_res: 32'd5,          exp_n: 1};
        tbl[2] = '{a: 32'h0000_1234,  b: 32'd0,          acc: 32'd5,          accum: 1'b0, exp_res: 32'd0,          exp_n: 1};
        tbl[3] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  acc: 32'd0,          accum: 1'b0, exp_res: 32'd1,          exp_n: 33};
        tbl[4] = '{a: 32'h8000_0000,  b: 32'd2,          acc: 32'h7FFF_FFFF,  accum: 1'b1, exp_res: 32'h7FFF_FFFF,  exp_n: 3};

        rst = 1'b1; start = 1'b0; accumulate = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0; op_acc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flag_n", 32'(flag_n), 32'd0);
        chk("reset flag_z", 32'(flag_z), 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].acc, tbl[i].accum, tbl[i].exp_res, tbl[i].exp_n,
                   $sformatf("tbl%0d", i));

        // Randomized operations with varied multiplier widths.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rc = $urandom;
            rm = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, rm, model_res(ra, rb, rc, rm), model_n(rb), $sformatf("rnd%0d", i));
        end

        // Start while busy is ignored; exactly one done pulse with the first result.
        @(negedge clk);
        op_a = 32'd6; op_b = 32'd7; accumulate = 1'b0; start = 1'b1;
        @(negedge clk);
        op_a = 32'd100; op_b = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (busy && done) chk("ign busy_and_done", 32'd1, 32'd0);
        end
        chk("ign done_pulses", 32'(pulses), 32'd1);
        chk("ign result", result, 32'd42);

        // Flush on the 3rd ITER cycle after establishing a prior result of 25.
        run_op(32'd5, 32'd5, 32'd0, 1'b0, 32'd25, 4, "pre_flush");
        @(negedge clk);
        op_a = 32'd6; op_b = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush done", 32'(done), 32'd0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("flush no_done", 32'(pulses), 32'd0);
        chk("flush result_held", result, 32'd25);
        run_op(32'd6, 32'd7, 32'd0, 1'b0, 32'd42, 4, "post_flush");

        // Asynchronous reset mid-run.
        @(negedge clk);
        op_a = 32'hFFFF_FFFF; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst flags", {30'd0, flag_n, flag_z}, 32'd0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        chk("rst no_activity", 32'(pulses), 32'd0);
        run_op(32'd6, 32'd7, 32'd0, 1'b0, 32'd42, 4, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer that executes ARMv4 MUL and MLA (low 32 bits of the product, optional accumulate) by driving the team's ALU through a shift-and-add loop. It sits beside the execute stage. The decoder issues one operation with a start pulse, and the sequencer returns a registered result with N/Z flags. The ALU is instantiated inside this block; the sequencer alone owns its selectCase, a and b inputs.

## Interface
- size, 32, operand/result width; the internal iteration counter is $clog2(size)+1 bits
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- accumulate  in  1  1 = MLA (acc + a*b), 0 = MUL (a*b); captured with start
- op_a  in  size  multiplicand; captured with start
- op_b  in  size  multiplier; captured with start
- op_acc  in  size  accumulate addend; captured with start, ignored when accumulate=0
- flush  in  1  synchronous abort from the pipeline
- busy  out  1  high while in ITER
- done  out  1  one-cycle pulse in DONE
- result  out  size  product (mod 2^size); holds until the next completed operation
- flag_n  out  1  result[size-1], registered with result
- flag_z  out  1  result==0, registered with result

## Operation
- States: IDLE, ITER, DONE.
- IDLE with start=1 at an edge:
  - mcand<=op_a, mplier<=op_b, acc<=accumulate?op_acc:0, cnt<=0.
  - Next state ITER.
- ITER, one step per cycle:
  - If mplier==0 or cnt==size: next state DONE; result<=acc, flag_n/flag_z<=from acc; no other update.
  - Otherwise: if mplier[0]==1, acc<=ALU out; mcand<=mcand<<1 (local shift, zero fill); mplier<=mplier>>1 (logical); cnt<=cnt+1.
- ALU drive during ITER: selectCase=4'd0 (add), a=acc, b=mcand. In IDLE/DONE: selectCase=4'd0, a=0, b=0. ALU flags are unused.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE.
- start in ITER or DONE is ignored: no queuing, no capture.
- flush=1 at an edge in ITER or DONE:
  - Next state IDLE.
  - result/flags keep their previous values.
  - done is not asserted on the following cycle.
  - flush in IDLE has no effect. flush has priority over loop completion.
- Arithmetic: all additions wrap modulo 2^size. There is no carry/overflow output; upper product bits are discarded.

## Timing
- Reset values (asynchronous): state=IDLE, busy=0, done=0, result=0, flag_n=0, flag_z=0. Internal registers are cleared.
- Reset mid-operation: the operation is abandoned immediately; no done pulse follows reset release.
- Number of ITER cycles: n = 1 if op_b==0, else msb_index(op_b)+2. Maximum is size+1 (e.g. 33 for op_b[31]=1).
- start edge T0 → busy high during cycles T0..T0+n-1 → done high in cycle T0+n.
- result/flags become valid in the same cycle as done (registered at the last ITER edge).
- Earliest next start: the edge ending the DONE cycle is not sampled, so back-to-back spacing is n+2 edges.
- busy and done are never high together.

## Test plan
- MUL 6×7: start with op_a=6, op_b=7, accumulate=0 → busy for 4 cycles, done in the 5th cycle after the start edge, result=42, flag_n=0, flag_z=0.
- MLA with zero multiplier: op_a=0x1234, op_b=0, op_acc=5, accumulate=1 → 1 ITER cycle, result=5. Then MUL with op_b=0 → result=0, flag_z=1.
- Wrap and maximum latency: op_a=op_b=0xFFFFFFFF, accumulate=0 → 33 ITER cycles, result=0x00000001. MLA 0x80000000×2 + 0x7FFFFFFF → result=0x7FFFFFFF, flag_n=0.
- Start while busy: second start with different operands during ITER → ignored; the first result completes unchanged and done pulses exactly once.
- Flush: flush asserted on the 3rd ITER cycle of 6×7 → IDLE next edge, no done, result still holds the prior value. A new start in the next IDLE cycle completes normally.
- Reset mid-run: assert rst asynchronously during ITER of 0xFFFFFFFF×3 → all outputs 0 immediately, no done after release. A fresh 6×7 returns 42.
